// File: rtl/cla_pipe_adder_if.sv
// Streaming operand/result bundle for cla_pipe_adder: valid/ready in, valid/ready out.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, WIDTH/STAGES bits resolved per stage.
// Optional signed saturation of the result: define CLA_PIPE_SAT_EN.
module cla_pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NG = SW / GROUP;

    if (GROUP == 0 || STAGES == 0 || STAGES > WIDTH / GROUP ||
        (WIDTH % (GROUP * STAGES)) != 0) begin : g_param_check
        $error("cla_pipe_adder: illegal WIDTH/GROUP/STAGES combination");
    end

    logic             advance;
    logic             r_v   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_ovf [STAGES];

    // Global stall: the whole pipe moves only when the result slot is free or taken.
    assign advance       = ~r_v[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.sum       = r_sum[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
    assign bus.ovf       = r_ovf[STAGES-1];

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        localparam int unsigned LO   = k * SW;
        localparam bit          LAST = (k == int'(STAGES) - 1);

        logic             v_i;
        logic             c_i;
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic [SW-1:0]    ps;
        logic [SW-1:0]    gs;
        logic [SW-1:0]    slice;
        logic [NG-1:0]    gp;
        logic [NG-1:0]    gg;
        logic [NG:0]      gk;
        logic [NG:0]      gpp;
        logic [NG:0]      gc;
        logic             c_msb;
        logic             n_ovf;
        logic [WIDTH-1:0] n_sum;

        // Subtraction folds into the operands once, before the first stage.
        if (k == 0) begin : g_head
            assign v_i = bus.in_valid;
            assign a_i = bus.a;
            assign b_i = bus.sub ? ~bus.b : bus.b;
            assign c_i = bus.cin ^ bus.sub;
            assign s_i = '0;
        end else begin : g_body
            assign v_i = r_v[k-1];
            assign a_i = r_a[k-1];
            assign b_i = r_b[k-1];
            assign c_i = r_c[k-1];
            assign s_i = r_sum[k-1];
        end

        assign ps = a_i[LO +: SW] ^ b_i[LO +: SW];
        assign gs = a_i[LO +: SW] & b_i[LO +: SW];

        for (genvar gi = 0; gi < int'(NG); gi++) begin : g_grp
            logic [GROUP-1:0] gp_b;
            logic [GROUP-1:0] gg_b;
            logic [GROUP-1:0] bc;
            logic [GROUP:0]   kg;
            logic [GROUP:0]   pp;

            assign gp_b = ps[gi*GROUP +: GROUP];
            assign gg_b = gs[gi*GROUP +: GROUP];

            // kg[j]: carry into bit j with zero carry-in; pp[j]: propagate of bits below j.
            always_comb begin : p_bit_la
                logic t;
                t  = 1'b0;
                kg = '0;
                pp = '0;
                pp[0] = 1'b1;
                for (int j = 1; j <= int'(GROUP); j++) begin
                    pp[j] = 1'b1;
                    for (int i = 0; i < j; i++) begin
                        pp[j] = pp[j] & gp_b[i];
                        t = gg_b[i];
                        for (int m = i + 1; m < j; m++) begin
                            t = t & gp_b[m];
                        end
                        kg[j] = kg[j] | t;
                    end
                end
            end

            for (genvar j = 0; j < int'(GROUP); j++) begin : g_bit
                assign bc[j] = kg[j] | (pp[j] & gc[gi]);
            end

            assign slice[gi*GROUP +: GROUP] = gp_b ^ bc;
            assign gp[gi] = pp[GROUP];
            assign gg[gi] = kg[GROUP];

            if (gi == int'(NG) - 1) begin : g_msb
                assign c_msb = bc[GROUP-1];
            end
        end

        // Group-level lookahead over the group generate/propagate pairs.
        always_comb begin : p_grp_la
            logic t;
            t   = 1'b0;
            gk  = '0;
            gpp = '0;
            gpp[0] = 1'b1;
            for (int j = 1; j <= int'(NG); j++) begin
                gpp[j] = 1'b1;
                for (int i = 0; i < j; i++) begin
                    gpp[j] = gpp[j] & gp[i];
                    t = gg[i];
                    for (int m = i + 1; m < j; m++) begin
                        t = t & gp[m];
                    end
                    gk[j] = gk[j] | t;
                end
            end
        end

        for (genvar x = 0; x <= int'(NG); x++) begin : g_gc
            assign gc[x] = gk[x] | (gpp[x] & c_i);
        end

        // Overflow is only meaningful in the last stage, where c_msb is the carry into bit WIDTH-1.
        always_comb begin : p_next
            n_sum = s_i;
            n_sum[LO +: SW] = slice;
            n_ovf = c_msb ^ gc[NG];
`ifdef CLA_PIPE_SAT_EN
            if (LAST && n_ovf) begin
                n_sum = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin : p_reg
            if (!rst_n) begin
                r_v[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_ovf[k] <= 1'b0;
            end else if (advance) begin
                r_v[k]   <= v_i;
                r_a[k]   <= a_i;
                r_b[k]   <= b_i;
                r_sum[k] <= n_sum;
                r_c[k]   <= gc[NG];
                r_ovf[k] <= n_ovf;
            end
        end
    end
endmodule
